native_to_axi: RTL

NATIVE_TO_AXI -- requirements
Module: native_to_axi

---
 rtl/native_axi_pkg.sv | 24 ++
 rtl/native_to_axi.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/native_axi_pkg.sv
// Shared types and constants for the native-cache-line to AXI4 burst bridge.
package native_axi_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WR_ADDR,
    WR_DATA,
    WR_RESP,
    RD_ADDR,
    RD_DATA,
    UPDATE
  } state_e;

  localparam logic [1:0] OP_WRITE   = 2'b10;
  localparam logic [1:0] OP_READ    = 2'b01;
  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [1:0] RESP_OKAY  = 2'b00;

  // Counter width that stays legal when only one beat exists.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/native_to_axi.sv
// Bridges one native cache-line request at a time onto fixed-length AXI4 INCR bursts;
// reads return the assembled line on the native update port.
module native_to_axi
  import native_axi_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 256,
  parameter int AXI_DW     = 64
) (
  input  logic                    clk,
  input  logic                    resetn,

  input  logic                    nat_request_valid,
  output logic                    nat_request_ready,
  input  logic [1:0]              nat_request_op,
  input  logic [ADDR_WIDTH-1:0]   nat_request_addr,
  input  logic [DATA_WIDTH-1:0]   nat_request_data,

  output logic                    nat_update_valid,
  input  logic                    nat_update_ready,
  output logic [DATA_WIDTH-1:0]   nat_update_data,

  output logic                    awvalid,
  input  logic                    awready,
  output logic [ADDR_WIDTH-1:0]   awaddr,
  output logic [7:0]              awlen,
  output logic [2:0]              awsize,
  output logic [1:0]              awburst,

  output logic                    wvalid,
  input  logic                    wready,
  output logic [AXI_DW-1:0]       wdata,
  output logic [AXI_DW/8-1:0]     wstrb,
  output logic                    wlast,

  input  logic                    bvalid,
  output logic                    bready,
  input  logic [1:0]              bresp,

  output logic                    arvalid,
  input  logic                    arready,
  output logic [ADDR_WIDTH-1:0]   araddr,
  output logic [7:0]              arlen,
  output logic [2:0]              arsize,
  output logic [1:0]              arburst,

  input  logic                    rvalid,
  output logic                    rready,
  input  logic [AXI_DW-1:0]       rdata,
  input  logic [1:0]              rresp,
  input  logic                    rlast,

  output logic                    bus_error
);

  localparam int BEATS    = DATA_WIDTH / AXI_DW;
  localparam int BEAT_W   = cnt_width(BEATS);
  localparam int OFFSET_W = $clog2(DATA_WIDTH / 8);

  localparam logic [BEAT_W-1:0]     LAST_BEAT = BEAT_W'(BEATS - 1);
  localparam logic [2:0]            AXI_SIZE  = 3'($clog2(AXI_DW / 8));
  localparam logic [ADDR_WIDTH-1:0] ADDR_MASK = ~ADDR_WIDTH'((64'd1 << OFFSET_W) - 64'd1);

  typedef logic [BEATS-1:0][AXI_DW-1:0] line_t;

  state_e                state_q, state_d;
  logic [BEAT_W-1:0]     beat_q,  beat_d;
  logic [ADDR_WIDTH-1:0] addr_q,  addr_d;
  line_t                 wline_q, wline_d;
  line_t                 rline_q, rline_d;
  logic                  err_q,   err_d;

  logic last_beat;
  assign last_beat = (beat_q == LAST_BEAT);

  always_comb begin
    // NOTE: every next-state signal gets its hold value first so no path leaves it unassigned (no latches).
    state_d = state_q;
    beat_d  = beat_q;
    addr_d  = addr_q;
    wline_d = wline_q;
    rline_d = rline_q;
    err_d   = err_q;

    case (state_q)
      IDLE: begin
        if (nat_request_valid) begin
          // Unknown ops are consumed here and simply dropped.
          case (nat_request_op)
            OP_WRITE: begin
              addr_d  = nat_request_addr & ADDR_MASK;
              wline_d = nat_request_data;
              state_d = WR_ADDR;
            end
            OP_READ: begin
              addr_d  = nat_request_addr & ADDR_MASK;
              wline_d = nat_request_data;
              state_d = RD_ADDR;
            end
            default: ;
          endcase
        end
      end

      WR_ADDR: if (awready) state_d = WR_DATA;

      WR_DATA: begin
        if (wready) begin
          if (last_beat) begin
            beat_d  = '0;
            state_d = WR_RESP;
          end else begin
            beat_d = beat_q + 1'b1;
          end
        end
      end

      WR_RESP: begin
        if (bvalid) begin
          if (bresp != RESP_OKAY) err_d = 1'b1;
          state_d = IDLE;
        end
      end

      RD_ADDR: if (arready) state_d = RD_DATA;

      RD_DATA: begin
        if (rvalid) begin
          rline_d[beat_q] = rdata;
          if ((rresp != RESP_OKAY) || (rlast != last_beat)) err_d = 1'b1;
          // The burst length is ours; rlast is only cross-checked, never trusted.
          if (last_beat) begin
            beat_d  = '0;
            state_d = UPDATE;
          end else begin
            beat_d = beat_q + 1'b1;
          end
        end
      end

      UPDATE: if (nat_update_ready) state_d = IDLE;

      default: state_d = IDLE;
    endcase
  end

  // NOTE: the line buffers are reset too so a stale line can never leak out after a reset.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      beat_q  <= '0;
      addr_q  <= '0;
      wline_q <= '0;
      rline_q <= '0;
      err_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the pre-edge values.
      state_q <= state_d;
      beat_q  <= beat_d;
      addr_q  <= addr_d;
      wline_q <= wline_d;
      rline_q <= rline_d;
      err_q   <= err_d;
    end
  end

  assign nat_request_ready = (state_q == IDLE);
  assign nat_update_valid  = (state_q == UPDATE);
  assign nat_update_data   = rline_q;

  assign awvalid = (state_q == WR_ADDR);
  assign awaddr  = addr_q;
  assign awlen   = 8'(BEATS - 1);
  assign awsize  = AXI_SIZE;
  assign awburst = BURST_INCR;

  assign wvalid  = (state_q == WR_DATA);
  assign wdata   = wline_q[beat_q];
  assign wstrb   = '1;
  assign wlast   = wvalid && last_beat;

  assign bready  = (state_q == WR_RESP);

  assign arvalid = (state_q == RD_ADDR);
  assign araddr  = addr_q;
  assign arlen   = 8'(BEATS - 1);
  assign arsize  = AXI_SIZE;
  assign arburst = BURST_INCR;

  assign rready  = (state_q == RD_DATA);

  assign bus_error = err_q;

endmodule
